// File: rtl/offchip_mem_arbiter_pkg.sv
// Shared definitions for the off-chip line-memory arbiter.
//   arb_state_t : transaction FSM encoding (IDLE -> GRANT -> WAIT -> DONE)
//   arb_owner_t : which requester owns the channel for the current transaction
//   TMO_CNT_W   : width of the saturating WAIT-cycle timeout counter
package offchip_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_I  = 2'd0,
    OWN_D  = 2'd1,
    OWN_WB = 2'd2
  } arb_owner_t;

  localparam int TMO_CNT_W = 8;

endpackage

// File: rtl/offchip_mem_arbiter_prio_sel.sv
// Combinational priority selector for the three off-chip requesters.
// Ports:
//   i_req_i, d_req_i, wb_req_i : level requests
//   starve_i                   : I-cache has lost MAX_WAIT arbitrations in a row
//   grant_o[2:0]               : one-hot winner {wb, d, i}; all zero when nobody requests
// Normal order is wb > d > i: a D refill must never overwrite a dirty line that is still
// waiting to be written back. A starved I request jumps ahead of everything.
module offchip_mem_arbiter_prio_sel (
  input  logic       i_req_i,
  input  logic       d_req_i,
  input  logic       wb_req_i,
  input  logic       starve_i,
  output logic [2:0] grant_o
);

  always_comb begin
    grant_o = 3'b000;
    if (i_req_i && starve_i) begin
      grant_o = 3'b001;
    end else if (wb_req_i) begin
      grant_o = 3'b100;
    end else if (d_req_i) begin
      grant_o = 3'b010;
    end else if (i_req_i) begin
      grant_o = 3'b001;
    end
  end

endmodule

// File: rtl/offchip_mem_arbiter.sv
// Arbiter sharing one off-chip line-memory channel between I-cache refill (read),
// D-cache refill (read) and D-cache dirty-line writeback (write).
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   i_req/d_req/wb_req              : level requests, held until the matching ack
//   i_addr/d_addr/wb_addr           : request byte addresses (aligned to a line here)
//   wb_wdata                        : writeback line, stable while wb_req is high
//   i_ack/d_ack/wb_ack              : one-cycle completion pulses
//   line_rdata                      : read line, valid with i_ack / d_ack
//   bus_err                         : with the ack when the transaction timed out
//   offchip_mem_addr/_wdata         : registered line address / write data
//   offchip_mem_read_en/_write_en   : strobes, held from GRANT until ready or timeout
//   offchip_mem_data/_ready         : read data and completion from memory
//   offchip_mem_read/write_busy     : transaction in flight (GRANT and WAIT)
//   dbg_state_o                     : current FSM state for observation
// Handshake: a requester raises req and keeps it high until it sees its ack; the arbiter
// samples reqs only in IDLE, so a request dropped before being granted is simply ignored,
// and one still high in the IDLE cycle after its ack starts a new transaction.
// Memory side: the strobe stays high until offchip_mem_ready is seen in WAIT; ready seen
// in GRANT is ignored. TIMEOUT must be at least 1.
module offchip_mem_arbiter
  import offchip_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 128,
  parameter int MAX_WAIT = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              d_req,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [LINE_W-1:0] wb_wdata,
  output logic              i_ack,
  output logic              d_ack,
  output logic              wb_ack,
  output logic [LINE_W-1:0] line_rdata,
  output logic              bus_err,
  output logic [ADDR_W-1:0] offchip_mem_addr,
  output logic              offchip_mem_read_en,
  output logic              offchip_mem_write_en,
  output logic [LINE_W-1:0] offchip_mem_wdata,
  input  logic [LINE_W-1:0] offchip_mem_data,
  input  logic              offchip_mem_ready,
  output logic              offchip_mem_read_busy,
  output logic              offchip_mem_write_busy,
  output arb_state_t        dbg_state_o
);

  localparam int IW_W = $clog2(MAX_WAIT + 1);
  localparam logic [IW_W-1:0]      I_WAIT_MAX = IW_W'(MAX_WAIT);
  localparam logic [TMO_CNT_W-1:0] TMO_LAST   = TMO_CNT_W'(TIMEOUT - 1);
  localparam logic [TMO_CNT_W-1:0] TMO_SAT    = '1;
  localparam logic [ADDR_W-1:0]    ALIGN_MASK = ~(ADDR_W'(LINE_W / 8 - 1));

  arb_state_t            state_q,  state_d;
  arb_owner_t            owner_q,  owner_d;
  logic [ADDR_W-1:0]     addr_q,   addr_d;
  logic [LINE_W-1:0]     wdata_q,  wdata_d;
  logic [LINE_W-1:0]     rdata_q,  rdata_d;
  logic                  err_q,    err_d;
  logic [TMO_CNT_W-1:0]  tmo_q,    tmo_d;
  logic [IW_W-1:0]       i_wait_q, i_wait_d;

  logic [2:0] grant;
  logic       starve;
  logic       xfer_active;

  assign starve = (i_wait_q == I_WAIT_MAX);

  offchip_mem_arbiter_prio_sel u_prio_sel (
    .i_req_i  (i_req),
    .d_req_i  (d_req),
    .wb_req_i (wb_req),
    .starve_i (starve),
    .grant_o  (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_I;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
      i_wait_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      i_wait_q <= i_wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    i_wait_d = i_wait_q;

    // Starvation counting only happens at arbitration; a dropped request forgets its history.
    if (!i_req) begin
      i_wait_d = '0;
    end

    case (state_q)
      ARB_IDLE: begin
        err_d = 1'b0;
        if (grant != 3'b000) begin
          state_d = ARB_GRANT;
          if (grant[2]) begin
            owner_d = OWN_WB;
            addr_d  = wb_addr & ALIGN_MASK;
            wdata_d = wb_wdata;
          end else if (grant[1]) begin
            owner_d = OWN_D;
            addr_d  = d_addr & ALIGN_MASK;
          end else begin
            owner_d = OWN_I;
            addr_d  = i_addr & ALIGN_MASK;
          end
        end
        if (i_req) begin
          if (grant[0]) begin
            i_wait_d = '0;
          end else if (i_wait_q != I_WAIT_MAX) begin
            i_wait_d = i_wait_q + IW_W'(1);
          end
        end
      end
      ARB_GRANT: begin
        tmo_d   = '0;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (tmo_q != TMO_SAT) begin
          tmo_d = tmo_q + TMO_CNT_W'(1);
        end
        // Ready wins over a timeout landing in the same cycle. The timeout fires in the
        // WAIT cycle whose increment brings tmo_cnt to TIMEOUT, i.e. after TIMEOUT WAIT cycles.
        if (offchip_mem_ready) begin
          rdata_d = offchip_mem_data;
          state_d = ARB_DONE;
        end else if (tmo_q >= TMO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Strobes and busy flags decode straight from registered state, so an asynchronous
  // reset removes them immediately without waiting for a clock.
  assign xfer_active            = (state_q == ARB_GRANT) || (state_q == ARB_WAIT);
  assign offchip_mem_read_en    = xfer_active && (owner_q != OWN_WB);
  assign offchip_mem_write_en   = xfer_active && (owner_q == OWN_WB);
  assign offchip_mem_read_busy  = offchip_mem_read_en;
  assign offchip_mem_write_busy = offchip_mem_write_en;
  assign offchip_mem_addr       = addr_q;
  assign offchip_mem_wdata      = wdata_q;

  assign i_ack      = (state_q == ARB_DONE) && (owner_q == OWN_I);
  assign d_ack      = (state_q == ARB_DONE) && (owner_q == OWN_D);
  assign wb_ack     = (state_q == ARB_DONE) && (owner_q == OWN_WB);
  assign bus_err    = (state_q == ARB_DONE) && err_q;
  assign line_rdata = rdata_q;
  assign dbg_state_o = state_q;

  // The owner must keep its request up while its transaction is on the bus.
  a_req_held_after_grant: assert property (@(posedge clk) disable iff (rst)
    xfer_active |-> ((owner_q == OWN_I  && i_req) ||
                     (owner_q == OWN_D  && d_req) ||
                     (owner_q == OWN_WB && wb_req)));

  a_one_strobe: assert property (@(posedge clk) disable iff (rst)
    !(offchip_mem_read_en && offchip_mem_write_en));

endmodule

// File: tb/tb_offchip_mem_arbiter.sv
module tb_offchip_mem_arbiter;
  import offchip_mem_arbiter_pkg::*;

  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 128;
  localparam int MAX_WAIT = 8;
  localparam int TIMEOUT  = 255;
  localparam logic [ADDR_W-1:0] ALIGN = 32'hFFFF_FFF0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              i_req, d_req, wb_req;
  logic [ADDR_W-1:0] i_addr, d_addr, wb_addr;
  logic [LINE_W-1:0] wb_wdata;
  logic              i_ack, d_ack, wb_ack;
  logic [LINE_W-1:0] line_rdata;
  logic              bus_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              read_en, write_en;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_data;
  logic              mem_ready;
  logic              read_busy, write_busy;
  arb_state_t        dbg_state;

  offchip_mem_arbiter #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .i_req                  (i_req),
    .d_req                  (d_req),
    .wb_req                 (wb_req),
    .i_addr                 (i_addr),
    .d_addr                 (d_addr),
    .wb_addr                (wb_addr),
    .wb_wdata               (wb_wdata),
    .i_ack                  (i_ack),
    .d_ack                  (d_ack),
    .wb_ack                 (wb_ack),
    .line_rdata             (line_rdata),
    .bus_err                (bus_err),
    .offchip_mem_addr       (mem_addr),
    .offchip_mem_read_en    (read_en),
    .offchip_mem_write_en   (write_en),
    .offchip_mem_wdata      (mem_wdata),
    .offchip_mem_data       (mem_data),
    .offchip_mem_ready      (mem_ready),
    .offchip_mem_read_busy  (read_busy),
    .offchip_mem_write_busy (write_busy),
    .dbg_state_o            (dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [1:0]        owner;
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    logic              err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // memory model controls / observations
  int mem_lat         = 2;
  bit mem_never       = 1'b0;
  int strobe_len      = 0;
  int last_strobe_len = 0;
  bit both_seen       = 1'b0;
  int i_left = 0, d_left = 0, wb_left = 0;

  function automatic logic [LINE_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
    return {a ^ 32'hDEAD_BEEF, ~a, a + 32'h0101_0101, a};
  endfunction

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] own, input logic [ADDR_W-1:0] a,
                          input logic [LINE_W-1:0] wd, input bit err);
    exp_t e;
    e.owner = own;
    e.is_wr = (own == 2'd2);
    e.addr  = a & ALIGN;
    e.wdata = wd;
    e.err   = err;
    e.rdata = err ? '0 : mem_fn(a & ALIGN);
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || i_left != 0 || d_left != 0 || wb_left != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain_in_budget"}, (n < budget), 1);
    repeat (2) @(negedge clk);
  endtask

  // Memory responder, requester ack handling and scoreboard compare, all at negedge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      strobe_len = 0;
      mem_ready  = 1'b0;
    end else begin
      if (read_en && write_en) both_seen = 1'b1;
      if (read_en || write_en) begin
        strobe_len++;
        if (strobe_len == 1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_strobe", 1, 0);
          end else begin
            chk("strobe_addr", mem_addr, exp_q[0].addr);
            chk("strobe_is_write", write_en, exp_q[0].is_wr);
            if (exp_q[0].is_wr) chk("strobe_wdata", mem_wdata, exp_q[0].wdata);
          end
        end
        mem_ready = !mem_never && (strobe_len == mem_lat);
        mem_data  = mem_fn(mem_addr);
      end else begin
        if (strobe_len != 0) last_strobe_len = strobe_len;
        strobe_len = 0;
        mem_ready  = 1'b0;
      end

      if (i_ack || d_ack || wb_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", {wb_ack, d_ack, i_ack}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_owner", {wb_ack, d_ack, i_ack}, 3'b001 << e.owner);
          chk("ack_bus_err", bus_err, e.err);
          if (!e.is_wr) chk("ack_line_rdata", line_rdata, e.rdata);
        end
        if (i_ack && i_left > 0) begin i_left--; if (i_left == 0) i_req = 1'b0; end
        if (d_ack && d_left > 0) begin d_left--; if (d_left == 0) d_req = 1'b0; end
        if (wb_ack && wb_left > 0) begin wb_left--; if (wb_left == 0) wb_req = 1'b0; end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    logic [ADDR_W-1:0] a0, a1;
    logic [LINE_W-1:0] wd;

    rst = 1'b1;
    i_req = 0; d_req = 0; wb_req = 0;
    i_addr = '0; d_addr = '0; wb_addr = '0; wb_wdata = '0;
    mem_data = '0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_read_en", read_en, 0);
    chk("rst_write_en", write_en, 0);
    chk("rst_busy", {read_busy, write_busy}, 0);
    chk("rst_acks", {i_ack, d_ack, wb_ack, bus_err}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_line_rdata", line_rdata, 0);
    chk("rst_state", dbg_state, ARB_IDLE);
    rst = 1'b0;
    @(negedge clk);

    // 1: lone I request, unaligned address, minimum latency (ack 3 cycles after sampling)
    push_exp(2'd0, 32'h0000_1234, '0, 1'b0);
    i_addr = 32'h0000_1234; i_left = 1; i_req = 1'b1;
    @(negedge clk);
    chk("t1_aligned_addr", mem_addr, 32'h0000_1230);
    chk("t1_read_en_at_grant", read_en, 1);
    n = 1;
    while (!i_ack && n < 20) begin @(negedge clk); n++; end
    chk("t1_ack_latency", n, 3);
    wait_drain("t1", 50);

    // 2: wb and d together -> write first, then the D read
    a0 = $urandom; a1 = $urandom;
    wd = {$urandom, $urandom, $urandom, $urandom};
    push_exp(2'd2, a0, wd, 1'b0);
    push_exp(2'd1, a1, '0, 1'b0);
    wb_addr = a0; wb_wdata = wd; d_addr = a1;
    wb_left = 1; d_left = 1;
    wb_req = 1'b1; d_req = 1'b1;
    wait_drain("t2", 100);

    // 3: D held continuously against I: eight D wins, I forced on its 9th arbitration
    d_addr = 32'h2000_0104; i_addr = 32'h3000_020C;
    for (int k = 0; k < MAX_WAIT; k++) push_exp(2'd1, 32'h2000_0104, '0, 1'b0);
    push_exp(2'd0, 32'h3000_020C, '0, 1'b0);
    push_exp(2'd1, 32'h2000_0104, '0, 1'b0);
    push_exp(2'd1, 32'h2000_0104, '0, 1'b0);
    d_left = MAX_WAIT + 2; i_left = 1;
    d_req = 1'b1; i_req = 1'b1;
    wait_drain("t3", 500);

    // 6: back-to-back D, next read_en two cycles after the ack
    a0 = $urandom_range(32'h0000_0000, 32'h0FFF_FFFF);
    d_addr = a0;
    push_exp(2'd1, a0, '0, 1'b0);
    push_exp(2'd1, a0, '0, 1'b0);
    d_left = 2; d_req = 1'b1;
    n = 0;
    while (!d_ack && n < 50) begin @(negedge clk); n++; end
    chk("t6_first_ack_seen", d_ack, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!read_en && n < 20);
    chk("t6_reissue_gap", n, 2);
    wait_drain("t6", 50);

    // 4: memory never answers -> strobe for GRANT + TIMEOUT WAIT cycles, error ack, zero data
    mem_never = 1'b1;
    push_exp(2'd0, 32'h5555_5558, '0, 1'b1);
    i_addr = 32'h5555_5558; i_left = 1; i_req = 1'b1;
    wait_drain("t4", TIMEOUT + 40);
    chk("t4_strobe_cycles", last_strobe_len, TIMEOUT + 1);
    mem_never = 1'b0;

    // 5: reset in the middle of a write's WAIT phase
    mem_never = 1'b1;
    wd = {$urandom, $urandom, $urandom, $urandom};
    push_exp(2'd2, 32'h7000_0040, wd, 1'b0);
    wb_addr = 32'h7000_0040; wb_wdata = wd; wb_left = 1; wb_req = 1'b1;
    n = 0;
    while (dbg_state != ARB_WAIT && n < 20) begin @(negedge clk); n++; end
    chk("t5_reached_wait", dbg_state, ARB_WAIT);
    repeat (3) @(negedge clk);
    chk("t5_write_en_before_rst", write_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_write_en", write_en, 0);
    chk("t5_async_busy", {read_busy, write_busy}, 0);
    chk("t5_async_ack", {wb_ack, bus_err}, 0);
    wb_req = 1'b0; wb_left = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mem_never = 1'b0;
    @(negedge clk);
    chk("t5_state_after_release", dbg_state, ARB_IDLE);
    chk("t5_no_ack_after_release", {i_ack, d_ack, wb_ack}, 0);
    repeat (3) @(negedge clk);

    // global properties
    chk("never_both_strobes", both_seen, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
